// File: rtl/time_set_ctrl.sv
// Mode and time-setting controller: one-second count enable, RUN/EDIT_HR/EDIT_MIN/COMMIT
// sequencing with shadow edit registers, and a single-cycle parallel load into the counter.
module time_set_ctrl #(
    parameter int CLK_DIV = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_p,
    input  logic       inc_p,
    input  logic       dec_p,
    input  logic [5:0] cur_sec,
    input  logic [5:0] cur_min,
    input  logic [4:0] cur_hr,
    output logic       cnt_en,
    output logic       load,
    output logic [5:0] load_sec,
    output logic [5:0] load_min,
    output logic [4:0] load_hr,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_EDIT_HR  = 2'd1,
        S_EDIT_MIN = 2'd2,
        S_COMMIT   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_chg;
    logic [PW-1:0]   r_pre;
    logic [PW-1:0]   w_pre_nxt;
    logic [4:0]      r_edit_hr;
    logic [4:0]      w_edit_hr_nxt;
    logic [5:0]      r_edit_min;
    logic [5:0]      w_edit_min_nxt;
    logic            r_cnt_en;
    logic            w_cnt_en_nxt;
    logic            r_blink;
    logic            w_blink_nxt;
    logic            r_load;
    logic            w_load_nxt;
    logic [4:0]      r_load_hr;
    logic [4:0]      w_load_hr_nxt;
    logic [5:0]      r_load_min;
    logic [5:0]      w_load_min_nxt;
    logic            w_adj;

    // Seconds are always zeroed on commit, so the live seconds value is not needed.
    logic            w_unused_sec;
    assign w_unused_sec = ^cur_sec;

    // Out-of-range captured values step to 0 going up and to the maximum going down.
    function automatic logic [4:0] hr_step(input logic [4:0] v, input logic up);
        if (up) begin
            return (v >= 5'd23) ? 5'd0 : v + 5'd1;
        end else begin
            return ((v == 5'd0) || (v > 5'd23)) ? 5'd23 : v - 5'd1;
        end
    endfunction

    function automatic logic [5:0] min_step(input logic [5:0] v, input logic up);
        if (up) begin
            return (v >= 6'd59) ? 6'd0 : v + 6'd1;
        end else begin
            return ((v == 6'd0) || (v > 6'd59)) ? 6'd59 : v - 6'd1;
        end
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; COMMIT always returns to RUN and ignores the buttons
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:      if (mode_p) w_state_nxt = S_EDIT_HR;  else w_state_nxt = S_RUN;
            S_EDIT_HR:  if (mode_p) w_state_nxt = S_EDIT_MIN; else w_state_nxt = S_EDIT_HR;
            S_EDIT_MIN: if (mode_p) w_state_nxt = S_COMMIT;   else w_state_nxt = S_EDIT_MIN;
            S_COMMIT:   w_state_nxt = S_RUN;
            default:    w_state_nxt = S_RUN;
        endcase
    end

    // Next values of prescaler, edit shadows and registered outputs
    always_comb begin
        w_chg          = (w_state_nxt != r_state);
        w_adj          = !mode_p && (inc_p ^ dec_p);
        w_edit_hr_nxt  = r_edit_hr;
        w_edit_min_nxt = r_edit_min;

        if (w_chg || (r_pre == PRE_MAX)) begin
            w_pre_nxt = '0;
        end else begin
            w_pre_nxt = r_pre + PW'(1'b1);
        end

        case (r_state)
            S_RUN: begin
                if (mode_p) begin
                    w_edit_hr_nxt  = cur_hr;
                    w_edit_min_nxt = cur_min;
                end else begin
                    w_edit_hr_nxt  = r_edit_hr;
                    w_edit_min_nxt = r_edit_min;
                end
            end
            S_EDIT_HR: begin
                if (w_adj) w_edit_hr_nxt = hr_step(r_edit_hr, inc_p);
                else       w_edit_hr_nxt = r_edit_hr;
            end
            S_EDIT_MIN: begin
                if (w_adj) w_edit_min_nxt = min_step(r_edit_min, inc_p);
                else       w_edit_min_nxt = r_edit_min;
            end
            default: begin
                w_edit_hr_nxt  = r_edit_hr;
                w_edit_min_nxt = r_edit_min;
            end
        endcase

        // A tick on the same edge as leaving RUN is dropped so it never lands in EDIT_HR.
        w_cnt_en_nxt = (r_state == S_RUN) && (w_state_nxt == S_RUN) && (r_pre == PRE_MAX);
        w_load_nxt   = (w_state_nxt == S_COMMIT);

        if (w_state_nxt == S_COMMIT && r_state == S_EDIT_MIN) begin
            w_load_hr_nxt  = r_edit_hr;
            w_load_min_nxt = r_edit_min;
        end else begin
            w_load_hr_nxt  = r_load_hr;
            w_load_min_nxt = r_load_min;
        end

        case (w_state_nxt)
            S_EDIT_HR, S_EDIT_MIN: begin
                if (w_chg) begin
                    w_blink_nxt = 1'b1;
                end else if ((r_pre == PRE_HALF) || (r_pre == PRE_MAX)) begin
                    w_blink_nxt = ~r_blink;
                end else begin
                    w_blink_nxt = r_blink;
                end
            end
            default: w_blink_nxt = 1'b0;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre      <= '0;
            r_edit_hr  <= 5'd0;
            r_edit_min <= 6'd0;
            r_cnt_en   <= 1'b0;
            r_blink    <= 1'b0;
            r_load     <= 1'b0;
            r_load_hr  <= 5'd0;
            r_load_min <= 6'd0;
        end else begin
            r_pre      <= w_pre_nxt;
            r_edit_hr  <= w_edit_hr_nxt;
            r_edit_min <= w_edit_min_nxt;
            r_cnt_en   <= w_cnt_en_nxt;
            r_blink    <= w_blink_nxt;
            r_load     <= w_load_nxt;
            r_load_hr  <= w_load_hr_nxt;
            r_load_min <= w_load_min_nxt;
        end
    end

    assign cnt_en   = r_cnt_en;
    assign load     = r_load;
    assign load_hr  = r_load_hr;
    assign load_min = r_load_min;
    assign load_sec = 6'd0;
    assign mode     = r_state;
    assign blink    = r_blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed vector table, corner-case sequences and
// random button traffic against a cycles-since-state-entry reference model.
module tb_time_set_ctrl;

    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode_p, inc_p, dec_p;
    logic [5:0] cur_sec, cur_min;
    logic [4:0] cur_hr;
    logic       cnt_en, load, blink;
    logic [5:0] load_sec, load_min;
    logic [4:0] load_hr;
    logic [1:0] mode;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode, cycles since entering that mode, shadows, last commit
    int m_mode, m_t, m_ehr, m_emin, m_lhr, m_lmin;

    typedef struct {
        bit mp, ip, dp;
        int e_mode, e_load, e_lhr, e_lmin, e_cnt, e_blink;
    } vec_t;
    vec_t tbl[$];

    time_set_ctrl #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .mode_p(mode_p), .inc_p(inc_p), .dec_p(dec_p),
        .cur_sec(cur_sec), .cur_min(cur_min), .cur_hr(cur_hr),
        .cnt_en(cnt_en), .load(load), .load_sec(load_sec), .load_min(load_min),
        .load_hr(load_hr), .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wrap_up(input int v, input int maxv);
        return (v > maxv) ? 0 : (v + 1) % (maxv + 1);
    endfunction

    function automatic int wrap_down(input int v, input int maxv);
        return (v > maxv) ? maxv : (v + maxv) % (maxv + 1);
    endfunction

    function automatic vec_t mk(input bit mp, input bit ip, input bit dp, input int em,
                                input int el, input int eh, input int en, input int ec,
                                input int eb);
        vec_t v;
        v.mp = mp; v.ip = ip; v.dp = dp;
        v.e_mode = em; v.e_load = el; v.e_lhr = eh; v.e_lmin = en; v.e_cnt = ec; v.e_blink = eb;
        return v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_ehr = 0; m_emin = 0; m_lhr = 0; m_lmin = 0;
    endtask

    task automatic model_edge(input bit mp, input bit ip, input bit dp);
        int prev;
        if (!rst_n) begin
            model_reset();
        end else begin
            prev = m_mode;
            case (m_mode)
                0: if (mp) begin m_ehr = cur_hr; m_emin = cur_min; m_mode = 1; end
                1: if (mp) m_mode = 2;
                   else if (ip != dp) m_ehr = ip ? wrap_up(m_ehr, 23) : wrap_down(m_ehr, 23);
                2: if (mp) begin m_mode = 3; m_lhr = m_ehr; m_lmin = m_emin; end
                   else if (ip != dp) m_emin = ip ? wrap_up(m_emin, 59) : wrap_down(m_emin, 59);
                default: m_mode = 0;
            endcase
            m_t = (m_mode != prev) ? 0 : m_t + 1;
        end
    endtask

    task automatic check_model();
        int exp_cnt, exp_blink;
        exp_cnt   = (m_mode == 0 && m_t > 0 && (m_t % DIV) == 0) ? 1 : 0;
        exp_blink = ((m_mode == 1 || m_mode == 2) && ((m_t / (DIV / 2)) % 2) == 0) ? 1 : 0;
        chk("mode", mode, m_mode);
        chk("load", load, (m_mode == 3) ? 1 : 0);
        chk("load_hr", load_hr, m_lhr);
        chk("load_min", load_min, m_lmin);
        chk("load_sec", load_sec, 0);
        chk("cnt_en", cnt_en, exp_cnt);
        chk("blink", blink, exp_blink);
    endtask

    task automatic step(input bit mp, input bit ip, input bit dp);
        mode_p = mp; inc_p = ip; dec_p = dp;
        @(posedge clk);
        model_edge(mp, ip, dp);
        #1;
        mode_p = 1'b0; inc_p = 1'b0; dec_p = 1'b0;
        check_model();
    endtask

    initial begin
        rst_n = 1'b0; mode_p = 1'b0; inc_p = 1'b0; dec_p = 1'b0;
        cur_sec = 6'd42; cur_min = 6'd17; cur_hr = 5'd5;
        model_reset();

        // Reset held for three cycles, then free-running seconds
        repeat (3) step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("idle_cnt_en", cnt_en, (i % DIV == 0) ? 1 : 0);
        end

        // Directed edit of 05:17:42 -> commit 08:15:00
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 2, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 2, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 2, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 2, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 3, 1, 8, 15, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 8, 15, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 8, 15, 0, 0));
        for (int i = 2; i <= 9; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 8, 15, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8, 15, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8, 15, 0, 0));
        foreach (tbl[k]) begin
            mode_p = tbl[k].mp; inc_p = tbl[k].ip; dec_p = tbl[k].dp;
            @(posedge clk);
            model_edge(tbl[k].mp, tbl[k].ip, tbl[k].dp);
            #1;
            mode_p = 1'b0; inc_p = 1'b0; dec_p = 1'b0;
            chk("tbl_mode", mode, tbl[k].e_mode);
            chk("tbl_load", load, tbl[k].e_load);
            chk("tbl_load_hr", load_hr, tbl[k].e_lhr);
            chk("tbl_load_min", load_min, tbl[k].e_lmin);
            chk("tbl_load_sec", load_sec, 0);
            chk("tbl_cnt_en", cnt_en, tbl[k].e_cnt);
            chk("tbl_blink", blink, tbl[k].e_blink);
        end

        // Wrap-around in both fields
        cur_hr = 5'd23; cur_min = 6'd0;
        step(1, 0, 0); step(0, 1, 0); step(1, 0, 0); step(1, 0, 0);
        chk("wrap_hr_up", load_hr, 0);
        step(0, 0, 0);
        step(1, 0, 0); step(0, 1, 0); step(0, 0, 1); step(1, 0, 0); step(0, 0, 1); step(1, 0, 0);
        chk("wrap_hr_down", load_hr, 23);
        chk("wrap_min_down", load_min, 59);
        step(0, 0, 0);
        step(1, 0, 0); step(1, 0, 0); step(0, 0, 1); step(0, 1, 0); step(1, 0, 0);
        chk("wrap_min_up", load_min, 0);
        step(0, 0, 0);

        // Out-of-range values captured on entry
        cur_hr = 5'd31; cur_min = 6'd63;
        step(1, 0, 0); step(0, 1, 0); step(1, 0, 0); step(0, 0, 1); step(1, 0, 0);
        chk("oor_hr_inc", load_hr, 0);
        chk("oor_min_dec", load_min, 59);
        step(0, 0, 0);
        step(1, 0, 0); step(0, 0, 1); step(1, 0, 0); step(0, 1, 0); step(1, 0, 0);
        chk("oor_hr_dec", load_hr, 23);
        chk("oor_min_inc", load_min, 0);
        step(0, 0, 0);

        // Blink in EDIT_HR, then COMMIT and the first second back in RUN
        cur_hr = 5'd5; cur_min = 6'd17;
        step(1, 0, 0);
        for (int i = 0; i < 15; i++) begin
            if (i > 0) step(0, 0, 0);
            chk("blink_edit_hr", blink, ((i / 5) % 2 == 0) ? 1 : 0);
        end
        step(1, 0, 0); step(1, 0, 0);
        chk("blink_commit", blink, 0);
        chk("commit_load", load, 1);
        for (int i = 0; i <= DIV; i++) begin
            step(0, 0, 0);
            chk("first_cnt_en", cnt_en, (i == DIV) ? 1 : 0);
        end

        // Reset in the middle of an edit
        step(1, 0, 0); step(0, 1, 0); step(1, 0, 0); step(0, 1, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mode", mode, 0);
        chk("rst_load", load, 0);
        chk("rst_load_hr", load_hr, 0);
        chk("rst_load_min", load_min, 0);
        chk("rst_cnt_en", cnt_en, 0);
        chk("rst_blink", blink, 0);
        step(0, 0, 0); step(0, 0, 0);
        rst_n = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            step(0, 0, 0);
            chk("rst_cnt_period", cnt_en, (i % DIV == 0) ? 1 : 0);
        end

        // Random button traffic against the model
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                cur_hr  = 5'($urandom_range(0, 31));
                cur_min = 6'($urandom_range(0, 63));
                cur_sec = 6'($urandom_range(0, 63));
            end
            step($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
